// File: rtl/except_commit_ctrl_pkg.sv
// Shared CPU defines for the exception commit controller.
// Holds the M-stage exception-type codes, the CP0 Cause.ExcCode values,
// the default exception entry vector and the commit FSM state encoding.
package except_commit_ctrl_pkg;

  // M-stage exception-type codes as presented on except_type
  localparam logic [31:0] EXC_T_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_T_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_T_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_T_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_T_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_T_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_T_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_T_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_T_ERET = 32'h0000_000e;

  // Cause.ExcCode values; ERET has no ExcCode and uses 0x0e as an internal tag
  localparam logic [4:0] EXCCODE_INT  = 5'h00;
  localparam logic [4:0] EXCCODE_ADEL = 5'h04;
  localparam logic [4:0] EXCCODE_ADES = 5'h05;
  localparam logic [4:0] EXCCODE_SYS  = 5'h08;
  localparam logic [4:0] EXCCODE_BP   = 5'h09;
  localparam logic [4:0] EXCCODE_RI   = 5'h0a;
  localparam logic [4:0] EXCCODE_OV   = 5'h0c;
  localparam logic [4:0] EXCCODE_ERET = 5'h0e;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hbfc0_0380;

  // Commit FSM state encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DRAIN    = 2'd1;
  localparam logic [1:0] ST_COMMIT   = 2'd2;
  localparam logic [1:0] ST_REDIRECT = 2'd3;

endpackage

// File: rtl/except_commit_ctrl.sv
// Exception commit controller.
// Captures an M-stage exception, drains outstanding data-SRAM traffic,
// issues a one-cycle CP0 exception-entry (or ERET EXL-clear) strobe and then
// holds a redirect request to fetch until accepted.
// Ports:
//   clk, resetn             clock, async active-low reset
//   except_type, pc_m, in_delayslot_m, badaddr_m, epc_in   M-stage capture inputs
//   mem_busy                data access outstanding (holds DRAIN)
//   redirect_ready          fetch accepts the redirect
//   flush_req, stall_req, busy                 pipeline control (non-IDLE)
//   cp0_we, cp0_exccode, cp0_bd, cp0_epc       CP0 exception-entry write
//   cp0_badv_we, cp0_badvaddr                  BadVAddr write
//   cp0_exl_clr                                ERET Status.EXL clear
//   redirect_valid, redirect_pc                fetch redirect
module except_commit_ctrl
  import except_commit_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int unsigned PC_W       = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [31:0]     except_type,
  input  logic [PC_W-1:0] pc_m,
  input  logic            in_delayslot_m,
  input  logic [PC_W-1:0] badaddr_m,
  input  logic            mem_busy,
  input  logic [PC_W-1:0] epc_in,
  input  logic            redirect_ready,
  output logic            flush_req,
  output logic            stall_req,
  output logic            cp0_we,
  output logic [4:0]      cp0_exccode,
  output logic            cp0_bd,
  output logic [PC_W-1:0] cp0_epc,
  output logic            cp0_badv_we,
  output logic [PC_W-1:0] cp0_badvaddr,
  output logic            cp0_exl_clr,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            busy
);

  // Returns {valid, exccode}; unsupported codes (including 0) yield valid=0
  function automatic logic [5:0] decode_exc(input logic [31:0] t);
    logic [5:0] r;
    r = '0;
    case (t)
      EXC_T_INT:  r = {1'b1, EXCCODE_INT};
      EXC_T_ADEL: r = {1'b1, EXCCODE_ADEL};
      EXC_T_ADES: r = {1'b1, EXCCODE_ADES};
      EXC_T_SYS:  r = {1'b1, EXCCODE_SYS};
      EXC_T_BP:   r = {1'b1, EXCCODE_BP};
      EXC_T_RI:   r = {1'b1, EXCCODE_RI};
      EXC_T_OV:   r = {1'b1, EXCCODE_OV};
      EXC_T_ERET: r = {1'b1, EXCCODE_ERET};
      default:    r = '0;
    endcase
    return r;
  endfunction

  logic [1:0]      state_q, state_d;
  logic [4:0]      code_q, code_d;
  logic            bd_q, bd_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] badaddr_q, badaddr_d;
  logic [PC_W-1:0] epc_q, epc_d;
  logic [5:0]      dec;

  always_comb begin
    dec       = decode_exc(except_type);
    state_d   = state_q;
    code_d    = code_q;
    bd_d      = bd_q;
    pc_d      = pc_q;
    badaddr_d = badaddr_q;
    epc_d     = epc_q;
    case (state_q)
      ST_IDLE: begin
        if (dec[5]) begin
          code_d    = dec[4:0];
          bd_d      = in_delayslot_m;
          pc_d      = pc_m;
          badaddr_d = badaddr_m;
          epc_d     = epc_in;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN:    if (!mem_busy) state_d = ST_COMMIT;
      ST_COMMIT:   state_d = ST_REDIRECT;
      ST_REDIRECT: if (redirect_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      code_q    <= '0;
      bd_q      <= 1'b0;
      pc_q      <= '0;
      badaddr_q <= '0;
      epc_q     <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      bd_q      <= bd_d;
      pc_q      <= pc_d;
      badaddr_q <= badaddr_d;
      epc_q     <= epc_d;
    end
  end

  // Outputs decode only state_q and captured registers; data fields are
  // gated to zero outside their strobe so IDLE/reset shows all-zero outputs.
  logic is_eret, in_commit, is_adex;

  always_comb begin
    is_eret        = (code_q == EXCCODE_ERET);
    is_adex        = (code_q == EXCCODE_ADEL) || (code_q == EXCCODE_ADES);
    in_commit      = (state_q == ST_COMMIT);
    busy           = (state_q != ST_IDLE);
    flush_req      = busy;
    stall_req      = busy;
    cp0_we         = in_commit && !is_eret;
    cp0_exl_clr    = in_commit && is_eret;
    cp0_exccode    = cp0_we ? code_q : '0;
    cp0_bd         = cp0_we && bd_q;
    cp0_epc        = cp0_we ? (bd_q ? pc_q - PC_W'(4) : pc_q) : '0;
    cp0_badv_we    = in_commit && is_adex;
    cp0_badvaddr   = cp0_badv_we ? badaddr_q : '0;
    redirect_valid = (state_q == ST_REDIRECT);
    redirect_pc    = redirect_valid ? (is_eret ? epc_q : PC_W'(EXC_VECTOR)) : '0;
  end

endmodule

// File: tb/tb_except_commit_ctrl.sv
module tb_except_commit_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] except_type = '0;
  logic [31:0] pc_m = '0;
  logic        in_delayslot_m = 1'b0;
  logic [31:0] badaddr_m = '0;
  logic        mem_busy = 1'b0;
  logic [31:0] epc_in = '0;
  logic        redirect_ready = 1'b1;
  logic        flush_req, stall_req, cp0_we, cp0_bd, cp0_badv_we, cp0_exl_clr;
  logic        redirect_valid, busy;
  logic [4:0]  cp0_exccode;
  logic [31:0] cp0_epc, cp0_badvaddr, redirect_pc;

  always #5 clk = ~clk;

  except_commit_ctrl #(.EXC_VECTOR(32'hbfc0_0380), .PC_W(32)) dut (
    .clk(clk), .resetn(resetn), .except_type(except_type), .pc_m(pc_m),
    .in_delayslot_m(in_delayslot_m), .badaddr_m(badaddr_m), .mem_busy(mem_busy),
    .epc_in(epc_in), .redirect_ready(redirect_ready), .flush_req(flush_req),
    .stall_req(stall_req), .cp0_we(cp0_we), .cp0_exccode(cp0_exccode),
    .cp0_bd(cp0_bd), .cp0_epc(cp0_epc), .cp0_badv_we(cp0_badv_we),
    .cp0_badvaddr(cp0_badvaddr), .cp0_exl_clr(cp0_exl_clr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  typedef struct {
    logic        eret;
    logic [4:0]  code;
    logic        bd;
    logic [31:0] epc;
    logic        badv_we;
    logic [31:0] badv;
  } commit_t;

  commit_t     cq[$];
  logic [31:0] rq[$];
  commit_t     exp_c;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT strobes CP0 or
  // presents a redirect; redirect_pc is checked every cycle it is valid.
  always @(negedge clk) begin
    if (resetn) begin
      if (cp0_we || cp0_exl_clr) begin
        if (cq.size() == 0) begin
          chk("unexpected_commit", {30'b0, cp0_we, cp0_exl_clr}, 32'h0);
        end else begin
          exp_c = cq.pop_front();
          chk("cp0_we",      32'(cp0_we),      32'(!exp_c.eret));
          chk("cp0_exl_clr", 32'(cp0_exl_clr), 32'(exp_c.eret));
          chk("cp0_badv_we", 32'(cp0_badv_we), 32'(exp_c.badv_we));
          if (!exp_c.eret) begin
            chk("cp0_exccode", 32'(cp0_exccode), 32'(exp_c.code));
            chk("cp0_bd",      32'(cp0_bd),      32'(exp_c.bd));
            chk("cp0_epc",     cp0_epc,          exp_c.epc);
          end
          if (exp_c.badv_we) chk("cp0_badvaddr", cp0_badvaddr, exp_c.badv);
        end
      end
      if (redirect_valid) begin
        if (rq.size() == 0) begin
          chk("unexpected_redirect", 32'(redirect_valid), 32'h0);
        end else begin
          chk("redirect_pc", redirect_pc, rq[0]);
          if (redirect_ready) void'(rq.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an exception for one IDLE cycle; returns one cycle later (cycle 1)
  task automatic present(input logic [31:0] t, input logic [31:0] pc, input logic ds,
                         input logic [31:0] bad, input logic [31:0] epc);
    except_type    = t;
    pc_m           = pc;
    in_delayslot_m = ds;
    badaddr_m      = bad;
    epc_in         = epc;
    tick();
    except_type    = '0;
    pc_m           = '0;
    in_delayslot_m = 1'b0;
    badaddr_m      = '0;
    epc_in         = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #12;
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_flush", 32'(flush_req), 32'h0);
    chk("rst_stall", 32'(stall_req), 32'h0);
    chk("rst_we",    32'(cp0_we), 32'h0);
    chk("rst_rv",    32'(redirect_valid), 32'h0);
    resetn = 1'b1;
    tick();

    // Sys, not in delay slot: cp0_we in cycle 2, redirect in cycle 3
    cq.push_back('{1'b0, 5'h08, 1'b0, 32'hbfc0_1000, 1'b0, 32'h0});
    rq.push_back(32'hbfc0_0380);
    chk("sys_c0_busy", 32'(busy), 32'h0);
    present(32'h8, 32'hbfc0_1000, 1'b0, 32'h0, 32'h0);
    chk("sys_c1_busy", 32'(busy), 32'h1);
    chk("sys_c1_we",   32'(cp0_we), 32'h0);
    tick();
    chk("sys_c2_we",   32'(cp0_we), 32'h1);
    chk("sys_c2_rv",   32'(redirect_valid), 32'h0);
    tick();
    chk("sys_c3_rv",   32'(redirect_valid), 32'h1);
    chk("sys_c3_we",   32'(cp0_we), 32'h0);
    tick();
    chk("sys_c4_busy", 32'(busy), 32'h0);

    // AdEL in delay slot
    cq.push_back('{1'b0, 5'h04, 1'b1, 32'hbfc0_2000, 1'b1, 32'h0000_0003});
    rq.push_back(32'hbfc0_0380);
    present(32'h4, 32'hbfc0_2004, 1'b1, 32'h0000_0003, 32'h0);
    tick(); tick(); tick();
    chk("adel_idle", 32'(busy), 32'h0);

    // ERET, then Ri in the first IDLE cycle after the redirect
    cq.push_back('{1'b1, 5'h0e, 1'b0, 32'h0, 1'b0, 32'h0});
    rq.push_back(32'hbfc0_0abc);
    present(32'he, 32'hbfc0_0100, 1'b0, 32'h0, 32'hbfc0_0abc);
    tick();
    chk("eret_exl", 32'(cp0_exl_clr), 32'h1);
    chk("eret_we",  32'(cp0_we), 32'h0);
    tick();
    chk("eret_rpc", redirect_pc, 32'hbfc0_0abc);
    tick();
    chk("b2b_idle", 32'(busy), 32'h0);
    cq.push_back('{1'b0, 5'h0a, 1'b0, 32'h8000_1004, 1'b0, 32'h0});
    rq.push_back(32'hbfc0_0380);
    present(32'ha, 32'h8000_1004, 1'b0, 32'h0, 32'h0);
    chk("b2b_accept", 32'(busy), 32'h1);
    tick(); tick(); tick();

    // Bp at pc 0 in delay slot (EPC wraps), mem_busy 4 cycles, ready low 3 cycles,
    // Ov presented while in REDIRECT
    cq.push_back('{1'b0, 5'h09, 1'b1, 32'hffff_fffc, 1'b0, 32'h0});
    rq.push_back(32'hbfc0_0380);
    mem_busy = 1'b1;
    redirect_ready = 1'b0;
    present(32'h9, 32'h0000_0000, 1'b1, 32'h0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_we", 32'(cp0_we), 32'h0);
      chk("drain_busy", 32'(busy), 32'h1);
      tick();
    end
    mem_busy = 1'b0;
    chk("drain_c5_we", 32'(cp0_we), 32'h0);
    tick();
    chk("drain_c6_we", 32'(cp0_we), 32'h1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("hold_rv", 32'(redirect_valid), 32'h1);
      except_type = (i == 1) ? 32'hc : 32'h0;
      tick();
    end
    except_type = '0;
    redirect_ready = 1'b1;
    chk("hold_rv_last", 32'(redirect_valid), 32'h1);
    tick();
    chk("hold_done_rv",   32'(redirect_valid), 32'h0);
    chk("hold_done_busy", 32'(busy), 32'h0);
    tick(); tick();

    // Unsupported code 0xd in IDLE
    except_type = 32'hd;
    tick();
    except_type = '0;
    chk("code_d_busy", 32'(busy), 32'h0);
    tick(); tick();

    // Reset asserted mid-DRAIN
    mem_busy = 1'b1;
    present(32'h1, 32'h8000_0040, 1'b0, 32'h0, 32'h0);
    chk("rstd_busy_pre", 32'(busy), 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk("rstd_busy",  32'(busy), 32'h0);
    chk("rstd_flush", 32'(flush_req), 32'h0);
    chk("rstd_stall", 32'(stall_req), 32'h0);
    chk("rstd_we",    32'(cp0_we), 32'h0);
    chk("rstd_rv",    32'(redirect_valid), 32'h0);
    mem_busy = 1'b0;
    @(posedge clk);
    #3 resetn = 1'b1;
    // AdES accepted on the first edge after reset release
    cq.push_back('{1'b0, 5'h05, 1'b0, 32'h0040_0008, 1'b1, 32'h0000_0006});
    rq.push_back(32'hbfc0_0380);
    except_type = 32'h5;
    pc_m        = 32'h0040_0008;
    badaddr_m   = 32'h0000_0006;
    tick();
    except_type = '0;
    pc_m        = '0;
    badaddr_m   = '0;
    chk("post_rst_accept", 32'(busy), 32'h1);
    tick(); tick(); tick(); tick();

    chk("commit_q_empty",   32'(cq.size()), 32'h0);
    chk("redirect_q_empty", 32'(rq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
